// File: rtl/bpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bpu_pkg
//  Description : Shared constants and helpers for the branch prediction unit:
//                PC width, saturating-counter init values and PC-to-index /
//                PC-to-tag extraction.
//  Revision    : 1.0 - initial release
// ============================================================================
package bpu_pkg;

  localparam int PC_W         = 32;
  localparam int CTR_MAX_BITS = 4;

  // Weakly-taken: MSB set, all lower bits clear.
  function automatic logic [CTR_MAX_BITS-1:0] ctr_weak_taken(input int bits);
    logic [CTR_MAX_BITS-1:0] v;
    v = '0;
    v[bits-1] = 1'b1;
    return v;
  endfunction

  // Weakly-not-taken: MSB clear, all lower bits set (one below weakly-taken).
  function automatic logic [CTR_MAX_BITS-1:0] ctr_weak_not_taken(input int bits);
    return ctr_weak_taken(bits) - 4'd1;
  endfunction

  // index = pc[idx_bits+1:2], returned zero-extended.
  function automatic logic [PC_W-1:0] pc_index(input logic [PC_W-1:0] pc,
                                               input int idx_bits);
    return (pc >> 2) & ((32'd1 << idx_bits) - 32'd1);
  endfunction

  // tag = pc[idx_bits+tag_bits+1:idx_bits+2], returned zero-extended.
  function automatic logic [PC_W-1:0] pc_tag(input logic [PC_W-1:0] pc,
                                             input int idx_bits,
                                             input int tag_bits);
    return (pc >> (idx_bits + 2)) & ((32'd1 << tag_bits) - 32'd1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/bpu_table.sv
`default_nettype none
// ============================================================================
//  Module      : bpu_table
//  Description : Prediction table storage (valid / tag / target / counter)
//                with one combinational read port and one write port. The
//                write port performs the counter read-modify-write itself:
//                a tag hit trains the counter, a miss allocates the entry.
//  Ports       : clk, rst_n      - clock, async active-low reset
//                rd_*            - read port (index in, entry fields out)
//                wr_*            - resolved-branch write port
//  Revision    : 1.0 - initial release
// ============================================================================
module bpu_table
  import bpu_pkg::*;
#(
  parameter int ENTRIES  = 64,
  parameter int CTR_BITS = 2,
  parameter int TAG_BITS = 8,
  localparam int IDX     = $clog2(ENTRIES)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [IDX-1:0]      rd_idx,
  output logic                rd_valid,
  output logic [TAG_BITS-1:0] rd_tag,
  output logic [PC_W-1:0]     rd_target,
  output logic                rd_ctr_msb,
  input  logic                wr_en,
  input  logic [IDX-1:0]      wr_idx,
  input  logic [TAG_BITS-1:0] wr_tag,
  input  logic                wr_taken,
  input  logic [PC_W-1:0]     wr_target
);

  localparam logic [CTR_BITS-1:0] CTR_WT  = CTR_BITS'(ctr_weak_taken(CTR_BITS));
  localparam logic [CTR_BITS-1:0] CTR_WNT = CTR_BITS'(ctr_weak_not_taken(CTR_BITS));
  localparam logic [CTR_BITS-1:0] CTR_MAX = {CTR_BITS{1'b1}};

  logic                valid_q  [ENTRIES];
  logic [TAG_BITS-1:0] tag_q    [ENTRIES];
  logic [PC_W-1:0]     target_q [ENTRIES];
  logic [CTR_BITS-1:0] ctr_q    [ENTRIES];

  // The read port sees the pre-write contents, so a lookup in the same
  // cycle as an update to the same index gets the old entry.
  assign rd_valid   = valid_q[rd_idx];
  assign rd_tag     = tag_q[rd_idx];
  assign rd_target  = target_q[rd_idx];
  assign rd_ctr_msb = ctr_q[rd_idx][CTR_BITS-1];

  logic                wr_hit;
  logic [CTR_BITS-1:0] wr_ctr_old;
  logic [CTR_BITS-1:0] wr_ctr_new;
  logic [PC_W-1:0]     wr_target_new;

  always_comb begin
    wr_hit        = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);
    wr_ctr_old    = ctr_q[wr_idx];
    wr_ctr_new    = wr_ctr_old;
    wr_target_new = target_q[wr_idx];
    if (wr_hit) begin
      if (wr_taken) begin
        if (wr_ctr_old != CTR_MAX) wr_ctr_new = wr_ctr_old + 1'b1;
        wr_target_new = wr_target;
      end else begin
        if (wr_ctr_old != '0) wr_ctr_new = wr_ctr_old - 1'b1;
      end
    end else begin
      wr_ctr_new    = wr_taken ? CTR_WT : CTR_WNT;
      wr_target_new = wr_target;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= CTR_WNT;
      end
    end else if (wr_en) begin
      valid_q[wr_idx]  <= 1'b1;
      tag_q[wr_idx]    <= wr_tag;
      target_q[wr_idx] <= wr_target_new;
      ctr_q[wr_idx]    <= wr_ctr_new;
    end
  end

endmodule
`default_nettype wire

// File: rtl/branch_predict_unit.sv
`default_nettype none
// ============================================================================
//  Module      : branch_predict_unit
//  Description : Direct-mapped branch predictor with tagged entries, per-entry
//                saturating counters and stored targets. Lookups are
//                registered one cycle; stall holds the outputs, flush kills
//                the pending prediction. Resolved branches train the table.
//  Ports       : clk, rst_n            - clock, async active-low reset
//                lookup_valid/pc       - IF-stage lookup request
//                stall, flush          - pipeline control
//                pred_*                - registered prediction
//                upd_*                 - EX-stage resolution / training
//                stat_clear, stat_*    - saturating statistics counters
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_predict_unit
  import bpu_pkg::*;
#(
  parameter int ENTRIES  = 64,
  parameter int CTR_BITS = 2,
  parameter int TAG_BITS = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        lookup_valid,
  input  logic [31:0] lookup_pc,
  input  logic        stall,
  input  logic        flush,
  output logic        pred_valid,
  output logic        pred_hit,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_mispredict,
  input  logic        stat_clear,
  output logic [31:0] stat_lookups,
  output logic [31:0] stat_mispredicts
);

  localparam int IDX = $clog2(ENTRIES);

  logic [IDX-1:0]      rd_idx;
  logic [TAG_BITS-1:0] rd_tag_req;
  logic                rd_valid;
  logic [TAG_BITS-1:0] rd_tag;
  logic [PC_W-1:0]     rd_target;
  logic                rd_ctr_msb;
  logic [IDX-1:0]      wr_idx;
  logic [TAG_BITS-1:0] wr_tag;

  assign rd_idx     = IDX'(pc_index(lookup_pc, IDX));
  assign rd_tag_req = TAG_BITS'(pc_tag(lookup_pc, IDX, TAG_BITS));
  assign wr_idx     = IDX'(pc_index(upd_pc, IDX));
  assign wr_tag     = TAG_BITS'(pc_tag(upd_pc, IDX, TAG_BITS));

  bpu_table #(
    .ENTRIES  (ENTRIES),
    .CTR_BITS (CTR_BITS),
    .TAG_BITS (TAG_BITS)
  ) u_table (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_idx     (rd_idx),
    .rd_valid   (rd_valid),
    .rd_tag     (rd_tag),
    .rd_target  (rd_target),
    .rd_ctr_msb (rd_ctr_msb),
    .wr_en      (upd_valid),
    .wr_idx     (wr_idx),
    .wr_tag     (wr_tag),
    .wr_taken   (upd_taken),
    .wr_target  (upd_target)
  );

  logic        lk_hit;
  logic        lk_taken;
  logic [31:0] lk_target;
  logic        lookup_accept;
  logic        mispredict_evt;

  always_comb begin
    lk_hit    = rd_valid && (rd_tag == rd_tag_req);
    lk_taken  = lk_hit && rd_ctr_msb;
    lk_target = lk_taken ? rd_target : (lookup_pc + 32'd4);
  end

  // Flush beats stall, and both suppress acceptance of a new lookup.
  assign lookup_accept  = lookup_valid && !stall && !flush;
  assign mispredict_evt = upd_valid && upd_mispredict;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pred_valid  <= 1'b0;
      pred_hit    <= 1'b0;
      pred_taken  <= 1'b0;
      pred_target <= '0;
    end else if (flush) begin
      pred_valid  <= 1'b0;
    end else if (!stall) begin
      pred_valid  <= lookup_valid;
      if (lookup_valid) begin
        pred_hit    <= lk_hit;
        pred_taken  <= lk_taken;
        pred_target <= lk_target;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_lookups     <= '0;
      stat_mispredicts <= '0;
    end else if (stat_clear) begin
      stat_lookups     <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (lookup_accept && !(&stat_lookups))
        stat_lookups <= stat_lookups + 32'd1;
      if (mispredict_evt && !(&stat_mispredicts))
        stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_branch_predict_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_branch_predict_unit
//  Description : Directed self-checking bench for branch_predict_unit
//                (default parameters: 64 entries, 2-bit counters, 8-bit tags).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_predict_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        lookup_valid;
  logic [31:0] lookup_pc;
  logic        stall;
  logic        flush;
  logic        pred_valid;
  logic        pred_hit;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_mispredict;
  logic        stat_clear;
  logic [31:0] stat_lookups;
  logic [31:0] stat_mispredicts;

  int errors = 0;
  int checks = 0;
  int exp_lookups = 0;

  branch_predict_unit dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .lookup_valid     (lookup_valid),
    .lookup_pc        (lookup_pc),
    .stall            (stall),
    .flush            (flush),
    .pred_valid       (pred_valid),
    .pred_hit         (pred_hit),
    .pred_taken       (pred_taken),
    .pred_target      (pred_target),
    .upd_valid        (upd_valid),
    .upd_pc           (upd_pc),
    .upd_taken        (upd_taken),
    .upd_target       (upd_target),
    .upd_mispredict   (upd_mispredict),
    .stat_clear       (stat_clear),
    .stat_lookups     (stat_lookups),
    .stat_mispredicts (stat_mispredicts)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_lookup(input logic [31:0] pc);
    lookup_valid = 1'b1;
    lookup_pc    = pc;
    tick();
    lookup_valid = 1'b0;
    exp_lookups++;
  endtask

  task automatic do_update(input logic [31:0] pc, input logic taken,
                           input logic [31:0] tgt, input logic mis);
    upd_valid      = 1'b1;
    upd_pc         = pc;
    upd_taken      = taken;
    upd_target     = tgt;
    upd_mispredict = mis;
    tick();
    upd_valid      = 1'b0;
    upd_mispredict = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; lookup_valid = 1'b0; lookup_pc = '0; stall = 1'b0; flush = 1'b0;
    upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0;
    upd_mispredict = 1'b0; stat_clear = 1'b0;
    #12;
    checks++;
    if ({pred_valid, pred_hit, pred_taken} !== 3'b000 || pred_target !== 32'h0) begin
      errors++;
      $display("FAIL reset_pred: got v/h/t=%b%b%b tgt=%h, want 000 tgt=0",
               pred_valid, pred_hit, pred_taken, pred_target);
    end
    checks++;
    if (stat_lookups !== 32'd0 || stat_mispredicts !== 32'd0) begin
      errors++;
      $display("FAIL reset_stats: got %0d/%0d, want 0/0", stat_lookups, stat_mispredicts);
    end
    checks++;
    if (dut.u_table.valid_q[0] !== 1'b0 || dut.u_table.ctr_q[0] !== 2'd1) begin
      errors++;
      $display("FAIL reset_entry: got valid=%b ctr=%0d, want valid=0 ctr=1",
               dut.u_table.valid_q[0], dut.u_table.ctr_q[0]);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_lookups = 0;
  endtask

  task automatic test_lookup_miss();
    do_lookup(32'h100);
    checks++;
    if ({pred_valid, pred_hit, pred_taken} !== 3'b100 || pred_target !== 32'h104) begin
      errors++;
      $display("FAIL miss_lookup: got v/h/t=%b%b%b tgt=%h, want 100 tgt=104",
               pred_valid, pred_hit, pred_taken, pred_target);
    end
    tick();
    checks++;
    if (pred_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_valid: got %b, want 0", pred_valid);
    end
  endtask

  task automatic test_allocate();
    do_update(32'h100, 1'b1, 32'h80, 1'b0);
    checks++;
    if (dut.u_table.ctr_q[0] !== 2'd2) begin
      errors++;
      $display("FAIL alloc_ctr: got %0d, want 2", dut.u_table.ctr_q[0]);
    end
    do_lookup(32'h100);
    checks++;
    if ({pred_valid, pred_hit, pred_taken} !== 3'b111 || pred_target !== 32'h80) begin
      errors++;
      $display("FAIL alloc_lookup: got v/h/t=%b%b%b tgt=%h, want 111 tgt=80",
               pred_valid, pred_hit, pred_taken, pred_target);
    end
  endtask

  task automatic test_counter();
    do_update(32'h100, 1'b0, 32'h0, 1'b0);
    do_update(32'h100, 1'b0, 32'h0, 1'b0);
    do_lookup(32'h100);
    checks++;
    if ({pred_hit, pred_taken} !== 2'b10 || pred_target !== 32'h104) begin
      errors++;
      $display("FAIL nt_lookup: got h/t=%b%b tgt=%h, want 10 tgt=104",
               pred_hit, pred_taken, pred_target);
    end
    for (int i = 0; i < 5; i++) do_update(32'h100, 1'b1, 32'h80, 1'b0);
    checks++;
    if (dut.u_table.ctr_q[0] !== 2'd3) begin
      errors++;
      $display("FAIL sat_ctr: got %0d, want 3", dut.u_table.ctr_q[0]);
    end
    // One not-taken from saturation leaves the entry predicting taken.
    do_update(32'h100, 1'b0, 32'h0, 1'b0);
    do_lookup(32'h100);
    checks++;
    if ({pred_hit, pred_taken} !== 2'b11 || pred_target !== 32'h80) begin
      errors++;
      $display("FAIL sat_lookup: got h/t=%b%b tgt=%h, want 11 tgt=80",
               pred_hit, pred_taken, pred_target);
    end
  endtask

  task automatic test_alias_rbw();
    do_lookup(32'h200);
    checks++;
    if ({pred_hit, pred_taken} !== 2'b00 || pred_target !== 32'h204) begin
      errors++;
      $display("FAIL alias_lookup: got h/t=%b%b tgt=%h, want 00 tgt=204",
               pred_hit, pred_taken, pred_target);
    end
    // Counter 2 -> 1 in the same cycle as a lookup: lookup sees old entry.
    upd_valid = 1'b1; upd_pc = 32'h100; upd_taken = 1'b0; upd_target = 32'h0;
    do_lookup(32'h100);
    upd_valid = 1'b0;
    checks++;
    if ({pred_hit, pred_taken} !== 2'b11 || pred_target !== 32'h80) begin
      errors++;
      $display("FAIL rbw_old: got h/t=%b%b tgt=%h, want 11 tgt=80",
               pred_hit, pred_taken, pred_target);
    end
    do_lookup(32'h100);
    checks++;
    if ({pred_hit, pred_taken} !== 2'b10 || pred_target !== 32'h104) begin
      errors++;
      $display("FAIL rbw_new: got h/t=%b%b tgt=%h, want 10 tgt=104",
               pred_hit, pred_taken, pred_target);
    end
  endtask

  task automatic test_stall_flush();
    do_lookup(32'h200);
    stall = 1'b1; lookup_valid = 1'b1; lookup_pc = 32'h100;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({pred_valid, pred_hit, pred_taken} !== 3'b100 || pred_target !== 32'h204) begin
        errors++;
        $display("FAIL stall_hold[%0d]: got v/h/t=%b%b%b tgt=%h, want 100 tgt=204",
                 i, pred_valid, pred_hit, pred_taken, pred_target);
      end
    end
    flush = 1'b1;
    tick();
    checks++;
    if (pred_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_stall: got pred_valid=%b, want 0", pred_valid);
    end
    stall = 1'b0;
    tick();
    checks++;
    if (pred_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_lookup: got pred_valid=%b, want 0", pred_valid);
    end
    flush = 1'b0; lookup_valid = 1'b0;
    checks++;
    if (stat_lookups !== 32'(exp_lookups)) begin
      errors++;
      $display("FAIL stat_lookups: got %0d, want %0d", stat_lookups, exp_lookups);
    end
  endtask

  task automatic test_stats();
    for (int i = 0; i < 3; i++) do_update(32'h400, 1'b1, 32'h40, 1'b1);
    // Mispredict flag without upd_valid must not count.
    upd_mispredict = 1'b1; tick(); upd_mispredict = 1'b0;
    checks++;
    if (stat_mispredicts !== 32'd3) begin
      errors++;
      $display("FAIL stat_mis3: got %0d, want 3", stat_mispredicts);
    end
    stat_clear = 1'b1;
    lookup_valid = 1'b1; lookup_pc = 32'h100;
    do_update(32'h400, 1'b1, 32'h40, 1'b1);
    stat_clear = 1'b0; lookup_valid = 1'b0;
    exp_lookups = 0;
    checks++;
    if (stat_mispredicts !== 32'd0 || stat_lookups !== 32'd0) begin
      errors++;
      $display("FAIL stat_clear: got %0d/%0d, want 0/0", stat_lookups, stat_mispredicts);
    end
  endtask

  task automatic test_reset_mid();
    lookup_valid = 1'b1; lookup_pc = 32'h100;
    upd_valid = 1'b1; upd_pc = 32'h100; upd_taken = 1'b1; upd_target = 32'h500;
    tick();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (pred_valid !== 1'b0 || pred_target !== 32'h0 || stat_lookups !== 32'd0) begin
      errors++;
      $display("FAIL async_reset: got v=%b tgt=%h lk=%0d, want 0/0/0",
               pred_valid, pred_target, stat_lookups);
    end
    @(posedge clk); #1;
    lookup_valid = 1'b0; upd_valid = 1'b0;
    rst_n = 1'b1;
    do_lookup(32'h100);
    checks++;
    if ({pred_valid, pred_hit, pred_taken} !== 3'b100 || pred_target !== 32'h104) begin
      errors++;
      $display("FAIL post_reset_miss: got v/h/t=%b%b%b tgt=%h, want 100 tgt=104",
               pred_valid, pred_hit, pred_taken, pred_target);
    end
  endtask

  initial begin
    test_reset();
    test_lookup_miss();
    test_allocate();
    test_counter();
    test_alias_rbw();
    test_stall_flush();
    test_stats();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
